// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S ADC capture path.
package i2s_pkg;

    localparam int I2S_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_e;

    typedef enum logic {
        CH_R = 1'b0,
        CH_L = 1'b1
    } ch_e;

    typedef struct packed {
        logic [I2S_DATA_W-1:0] l;
        logic [I2S_DATA_W-1:0] r;
    } pair_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered count, head word read combinationally.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en, rd_en;

    // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
    always_comb begin
        rd_en = pop && (cnt_q != '0);
        wr_en = push && ((cnt_q != CW'(DEPTH)) || rd_en);
        wr_d  = wr_q + AW'(wr_en);
        rd_d  = rd_q + AW'(rd_en);
        cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
        full  = cnt_q == CW'(DEPTH);
        empty = cnt_q == '0;
        dout  = mem_q[rd_q];
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/i2s_adc_capture.sv
// i2s_adc_capture: left-justified I2S ADC deserializer pairing L/R words into a FIFO.
// Optional per-channel peak meters are built when I2S_CAPTURE_PEAK_EN is defined.
module i2s_adc_capture
    import i2s_pkg::*;
#(
    parameter int DATA_W     = I2S_DATA_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i2s_bclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_adcdat,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overflow,
    output logic              frame_err,
    input  logic              clear_flags
`ifdef I2S_CAPTURE_PEAK_EN
    ,
    output logic [DATA_W-2:0] peak_l,
    output logic [DATA_W-2:0] peak_r
`endif
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int PAIR_W = 2 * DATA_W;

    // Bit order in the synchronizer: {lrclk, bclk, adcdat}.
    logic [2:0]        meta_q, sync_q, arm_q;
    logic              bclk_prev_q, lrclk_prev_q;
    logic              bclk_rise, lr_edge, lr_lvl, din;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, left_q, left_d, word;
    ch_e               ch_q, ch_d;
    logic              left_ok_q, left_ok_d;
    logic              push_q, push_d;
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic              frame_err_q, frame_err_d, overflow_q, overflow_d;
    logic              ferr_evt, ovf_evt, push_ok, pop;
    logic              fifo_full, fifo_empty;
    logic [PAIR_W-1:0] fifo_dout;

    // All three inputs share one synchronizer so bclk, lrclk and data stay aligned;
    // arm_q masks edges until the edge register holds a real input sample after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q       <= '0;
            sync_q       <= '0;
            bclk_prev_q  <= 1'b0;
            lrclk_prev_q <= 1'b0;
            arm_q        <= '0;
        end else begin
            meta_q       <= {i2s_lrclk, i2s_bclk, i2s_adcdat};
            sync_q       <= meta_q;
            bclk_prev_q  <= sync_q[1];
            lrclk_prev_q <= sync_q[2];
            arm_q        <= {arm_q[1:0], 1'b1};
        end
    end

    // Edge strobes and the data bit seen alongside them.
    always_comb begin
        bclk_rise = arm_q[2] && sync_q[1] && !bclk_prev_q;
        lr_edge   = arm_q[2] && (sync_q[2] ^ lrclk_prev_q);
        lr_lvl    = sync_q[2];
        din       = sync_q[0];
    end

    // Word FSM: lrclk edges restart a word, bclk rises shift MSB first, a full word
    // is latched and paired; a completed pair is registered for the FIFO write.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ch_d      = ch_q;
        left_d    = left_q;
        left_ok_d = left_ok_q;
        push_d    = 1'b0;
        pair_d    = pair_q;
        ferr_evt  = 1'b0;
        word      = {shreg_q[DATA_W-2:0], din};
        if (lr_edge) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            shreg_d   = '0;
            ch_d      = ch_e'(lr_lvl);
            if (state_q == SHIFT) begin
                ferr_evt  = 1'b1;
                left_ok_d = 1'b0;
            end
        end else if (state_q == SHIFT && bclk_rise) begin
            shreg_d   = word;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                state_d = HOLD;
                if (ch_q == CH_L) begin
                    left_d    = word;
                    left_ok_d = 1'b1;
                end else if (left_ok_q) begin
                    push_d    = 1'b1;
                    pair_d    = {left_q, word};
                    left_ok_d = 1'b0;
                end
            end
        end
    end

    // Word FSM and pairing registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ch_q      <= CH_R;
            left_q    <= '0;
            left_ok_q <= 1'b0;
            push_q    <= 1'b0;
            pair_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ch_q      <= ch_d;
            left_q    <= left_d;
            left_ok_q <= left_ok_d;
            push_q    <= push_d;
            pair_q    <= pair_d;
        end
    end

    sync_fifo #(
        .WIDTH(PAIR_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (push_q),
        .din  (pair_q),
        .full (fifo_full),
        .pop  (pop),
        .dout (fifo_dout),
        .empty(fifo_empty)
    );

    // Sticky flags; a coinciding event beats clear_flags.
    always_comb begin
        pop          = sample_valid && sample_ready;
        push_ok      = push_q && (!fifo_full || pop);
        ovf_evt      = push_q && fifo_full && !pop;
        frame_err_d  = ferr_evt || (frame_err_q && !clear_flags);
        overflow_d   = ovf_evt || (overflow_q && !clear_flags);
        sample_valid = !fifo_empty;
        sample_l     = fifo_empty ? '0 : fifo_dout[PAIR_W-1:DATA_W];
        sample_r     = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
        frame_err    = frame_err_q;
        overflow     = overflow_q;
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef I2S_CAPTURE_PEAK_EN
    logic [DATA_W-2:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
    logic [DATA_W-2:0] mag_l, mag_r, base_l, base_r;

    // |w| on DATA_W bits; the most negative code has no positive twin and saturates.
    function automatic logic [DATA_W-2:0] mag(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] n;
        n = -w;
        return w[DATA_W-1] ? (n[DATA_W-1] ? {(DATA_W-1){1'b1}} : n[DATA_W-2:0]) : w[DATA_W-2:0];
    endfunction

    // Peak tracks only pairs that actually enter the FIFO.
    always_comb begin
        mag_l    = mag(pair_q[PAIR_W-1:DATA_W]);
        mag_r    = mag(pair_q[DATA_W-1:0]);
        base_l   = clear_flags ? '0 : peak_l_q;
        base_r   = clear_flags ? '0 : peak_r_q;
        peak_l_d = (push_ok && mag_l > base_l) ? mag_l : base_l;
        peak_r_d = (push_ok && mag_r > base_r) ? mag_r : base_r;
        peak_l   = peak_l_q;
        peak_r   = peak_r_q;
    end

    // Peak registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_adc_capture.sv
// tb_i2s_adc_capture: scoreboard bench driving I2S frames into i2s_adc_capture.
module tb_i2s_adc_capture;

    localparam int W = 24;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic bclk = 1'b0;
    logic lrclk = 1'b0;
    logic dat = 1'b0;
    logic ready = 1'b1;
    logic clr = 1'b0;
    logic [W-1:0] sl, sr;
    logic sv, ovf, ferr;
`ifdef I2S_CAPTURE_PEAK_EN
    logic [W-2:0] pl, pr;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    always #5 clk = ~clk;

    i2s_adc_capture #(.DATA_W(W), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i2s_bclk    (bclk),
        .i2s_lrclk   (lrclk),
        .i2s_adcdat  (dat),
        .sample_l    (sl),
        .sample_r    (sr),
        .sample_valid(sv),
        .sample_ready(ready),
        .overflow    (ovf),
        .frame_err   (ferr),
        .clear_flags (clr)
`ifdef I2S_CAPTURE_PEAK_EN
        ,
        .peak_l      (pl),
        .peak_r      (pr)
`endif
    );

    // Scoreboard: every accepted head pair must match the oldest expected pair.
    always @(negedge clk) begin
        if (rstn && sv && ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pair got l=%h r=%h, required no pair", sl, sr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({sl, sr} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL pair_data got l=%h r=%h, required l=%h r=%h",
                             sl, sr, mon_exp[2*W-1:W], mon_exp[W-1:0]);
                end
            end
        end
    end

    // One I2S bit = 16 clk low then 16 clk high; lrclk/data change with bclk falling.
    task automatic send_word(input logic ch, input logic [W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            lrclk = ch;
            dat   = w[W-1-i];
            bclk  = 1'b0;
            repeat (16) @(negedge clk);
            bclk = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready = v;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || sv); i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({sv, ovf, ferr} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got valid/ovf/ferr=%b, required 000", {sv, ovf, ferr});
        end
        vectors++;
        if ({sl, sr} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got l=%h r=%h, required 0", sl, sr);
        end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_pair();
        int first, pulses;
        logic [W-1:0] r;
        r = 24'h800001;
        first = 0;
        pulses = 0;
        exp_q.push_back({24'h7FFFFF, r});
        send_word(1'b1, 24'h7FFFFF, 24);
        send_word(1'b0, r, 23);
        lrclk = 1'b0;
        dat   = r[0];
        bclk  = 1'b0;
        repeat (16) @(negedge clk);
        bclk = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (sv) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (first !== 4) begin
            miscompares++;
            $display("FAIL valid_latency got %0d clk after last bclk rise, required 4", first);
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL valid_pulses got %0d, required 1", pulses);
        end
        wait_drain();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_pair_out got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        set_ready(1'b0);
        @(negedge clk);
        for (int i = 1; i <= 12; i++) begin
            if (i <= 8) exp_q.push_back({24'(i), 24'(i)});
            send_word(1'b1, 24'(i), 24);
            send_word(1'b0, 24'(i), 24);
        end
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set got %b, required 1", ovf);
        end
        vectors++;
        if ({sv, sl, sr} !== {1'b1, 24'h1, 24'h1}) begin
            miscompares++;
            $display("FAIL full_head got v=%b l=%h r=%h, required v=1 l=000001 r=000001", sv, sl, sr);
        end
        set_ready(1'b1);
        wait_drain();
        vectors++;
        if (exp_q.size() != 0 || sv !== 1'b0) begin
            miscompares++;
            $display("FAIL drain got %0d pending valid=%b, required 0 pending valid=0", exp_q.size(), sv);
        end
        pulse_clear();
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear got %b, required 0", ovf);
        end
    endtask

    task automatic test_frame_err();
        @(negedge clk);
        send_word(1'b1, 24'hABCDEF, 10);
        send_word(1'b0, 24'h111111, 24);
        vectors++;
        if (ferr !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_err_set got %b, required 1", ferr);
        end
        vectors++;
        if (sv !== 1'b0) begin
            miscompares++;
            $display("FAIL orphan_right got valid=%b, required 0", sv);
        end
        exp_q.push_back({24'h123456, 24'h654321});
        send_word(1'b1, 24'h123456, 24);
        send_word(1'b0, 24'h654321, 24);
        wait_drain();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL recovery_pair got %0d pending, required 0", exp_q.size());
        end
        pulse_clear();
        vectors++;
        if (ferr !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err_clear got %b, required 0", ferr);
        end
    endtask

    task automatic test_midword_start();
        @(negedge clk);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        send_word(1'b0, 24'hFFFFFF, 12);
        vectors++;
        if (sv !== 1'b0) begin
            miscompares++;
            $display("FAIL midword_no_out got valid=%b, required 0", sv);
        end
        exp_q.push_back({24'h0A0B0C, 24'h0D0E0F});
        send_word(1'b1, 24'h0A0B0C, 24);
        send_word(1'b0, 24'h0D0E0F, 24);
        wait_drain();
        vectors++;
        if (exp_q.size() != 0 || ferr !== 1'b0) begin
            miscompares++;
            $display("FAIL midword_first_pair got %0d pending ferr=%b, required 0 pending ferr=0",
                     exp_q.size(), ferr);
        end
    endtask

    task automatic test_reset_midword();
        set_ready(1'b0);
        @(negedge clk);
        send_word(1'b1, 24'h222222, 24);
        send_word(1'b0, 24'h333333, 24);
        vectors++;
        if ({sv, sl} !== {1'b1, 24'h222222}) begin
            miscompares++;
            $display("FAIL pre_reset_head got v=%b l=%h, required v=1 l=222222", sv, sl);
        end
        send_word(1'b1, 24'h111111, 24);
        send_word(1'b0, 24'h777777, 12);
        rstn = 1'b0;
        #1;
        vectors++;
        if ({sv, sl, sr} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b l=%h r=%h, required all 0", sv, sl, sr);
        end
        @(negedge clk);
        rstn = 1'b1;
        set_ready(1'b1);
        @(negedge clk);
        send_word(1'b0, 24'h777777, 11);
        vectors++;
        if (sv !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_partial got valid=%b, required 0", sv);
        end
        exp_q.push_back({24'h444444, 24'h555555});
        send_word(1'b1, 24'h444444, 24);
        send_word(1'b0, 24'h555555, 24);
        wait_drain();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_pair got %0d pending, required 0", exp_q.size());
        end
    endtask

`ifdef I2S_CAPTURE_PEAK_EN
    task automatic test_peak();
        logic [W-1:0] words [3];
        logic [W-2:0] peaks [3];
        words[0] = 24'hFFFF00;
        words[1] = 24'h000050;
        words[2] = 24'h800000;
        peaks[0] = 23'h000100;
        peaks[1] = 23'h000100;
        peaks[2] = 23'h7FFFFF;
        pulse_clear();
        vectors++;
        if ({pl, pr} !== '0) begin
            miscompares++;
            $display("FAIL peak_clear_start got l=%h r=%h, required 0", pl, pr);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({words[i], words[i]});
            send_word(1'b1, words[i], 24);
            send_word(1'b0, words[i], 24);
            vectors++;
            if (pl !== peaks[i] || pr !== peaks[i]) begin
                miscompares++;
                $display("FAIL peak_%0d got l=%h r=%h, required %h", i, pl, pr, peaks[i]);
            end
        end
        pulse_clear();
        vectors++;
        if ({pl, pr} !== '0) begin
            miscompares++;
            $display("FAIL peak_clear got l=%h r=%h, required 0", pl, pr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_pair();
        test_overflow();
        test_frame_err();
        test_midword_start();
        test_reset_midword();
`ifdef I2S_CAPTURE_PEAK_EN
        test_peak();
`endif
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
